// File: rtl/rng_share_ctrl_pkg.sv
// Shared definitions for the shared-LFSR random source: FSM encoding, LFSR
// geometry, reset seed and the step function used by the datapath.
package rng_share_ctrl_pkg;

    localparam int LFSR_W = 8;
    localparam int CNT_W  = 8;
    localparam logic [LFSR_W-1:0] LFSR_RESET_SEED = 8'h01;

    // Feedback taps for x^8+x^6+x^5+x^4+1 in shift-left form.
    localparam int TAP_HI = 7;
    localparam int TAP_A  = 5;
    localparam int TAP_B  = 4;
    localparam int TAP_C  = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], v[TAP_HI] ^ v[TAP_A] ^ v[TAP_B] ^ v[TAP_C]};
    endfunction

endpackage

// File: rtl/rng_share_ctrl_lfsr8_en.sv
// 8-bit Fibonacci LFSR that advances only when enabled and can be loaded
// with a new seed; load wins over step.
module lfsr8_en
    import rng_share_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              ar,
    input  logic              step_en,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] value
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            value <= LFSR_RESET_SEED;
        end else if (load) begin
            value <= load_val;
        end else if (step_en) begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/rng_share_ctrl.sv
// Round-robin sharing of one LFSR between two requesters; each grant runs the
// LFSR STEPS shifts and returns the result with a one-cycle ack.
module rng_share_ctrl
    import rng_share_ctrl_pkg::*;
#(
    parameter int STEPS = 8
) (
    input  logic              clk,
    input  logic              ar,
    input  logic              seed_we,
    input  logic [LFSR_W-1:0] seed,
    input  logic [1:0]        req,
    output logic [1:0]        ack,
    output logic [LFSR_W-1:0] data,
    output logic              busy
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count;
    logic               grant_idx;
    logic               last_idx;
    logic               arb_idx;
    logic               start;
    logic               step_en;
    logic               lfsr_load;
    logic [LFSR_W-1:0]  lfsr_load_val;
    logic [LFSR_W-1:0]  lfsr_value;

    lfsr8_en u_lfsr (
        .clk      (clk),
        .ar       (ar),
        .step_en  (step_en),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .value    (lfsr_value)
    );

    // An all-zero seed would lock the LFSR, so it is replaced by the reset seed.
    assign lfsr_load_val = (seed == '0) ? LFSR_RESET_SEED : seed;

    // A lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        if (req == 2'b01) begin
            arb_idx = 1'b0;
        end else if (req == 2'b10) begin
            arb_idx = 1'b1;
        end else begin
            arb_idx = ~last_idx;
        end
    end

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        unique case (state)
            S_IDLE: begin
                start = !seed_we && (req != 2'b00);
                if (start) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (count == CNT_W'(1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ack       = 2'b00;
        busy      = (state != S_IDLE);
        step_en   = (state == S_SHIFT);
        lfsr_load = (state == S_IDLE) && seed_we;
        if (state == S_DONE) begin
            ack[grant_idx] = 1'b1;
        end
    end

    // data captures the post-final-shift value so it is valid alongside ack.
    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            count     <= '0;
            grant_idx <= 1'b0;
            last_idx  <= 1'b1;
            data      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        count     <= CNT_W'(STEPS);
                        grant_idx <= arb_idx;
                    end
                end
                S_SHIFT: begin
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        data <= lfsr_step(lfsr_value);
                    end
                end
                S_DONE: begin
                    last_idx <= grant_idx;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rng_share_ctrl.sv
// Self-checking bench for rng_share_ctrl; expected samples come from a table
// of the full 255-state LFSR orbit indexed by position.
module tb_rng_share_ctrl;

    localparam int STEPS  = 8;
    localparam int PERIOD = 255;
    localparam int BUDGET = 3 * STEPS + 20;

    logic       clk = 1'b0;
    logic       ar = 1'b0;
    logic       seed_we = 1'b0;
    logic [7:0] seed = 8'h00;
    logic [1:0] req = 2'b00;
    logic [1:0] ack;
    logic [7:0] data;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] seq_tab [PERIOD];
    int         pos;
    logic       last_served;

    rng_share_ctrl #(.STEPS(STEPS)) dut (
        .clk     (clk),
        .ar      (ar),
        .seed_we (seed_we),
        .seed    (seed),
        .req     (req),
        .ack     (ack),
        .data    (data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic build_table();
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < PERIOD; i++) begin
            seq_tab[i] = v;
            v = {v[6:0], ^(v & 8'hB8)};
        end
    endtask

    task automatic model_sample(output logic [7:0] s);
        pos = (pos + STEPS) % PERIOD;
        s = seq_tab[pos];
    endtask

    task automatic model_seed(input logic [7:0] s);
        logic [7:0] v;
        v = (s == 8'h00) ? 8'h01 : s;
        for (int i = 0; i < PERIOD; i++) begin
            if (seq_tab[i] == v) pos = i;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (ack == 2'b00 && lat < BUDGET);
    endtask

    task automatic apply_reset();
        ar = 1'b0;
        req = 2'b00;
        seed_we = 1'b0;
        tick();
        tick();
        ar = 1'b1;
        pos = 0;
        last_served = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if (ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b expected 00", ack); end
        checks++;
        if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        ar = 1'b1;
        pos = 0;
        last_served = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        logic [7:0] exp_d;
        int lat;
        for (int n = 0; n < 2; n++) begin
            req = 2'b01;
            wait_ack(lat);
            model_sample(exp_d);
            last_served = 1'b0;
            req = 2'b00;
            checks++;
            if (ack !== 2'b01) begin errors++; $display("FAIL single_ack%0d: got %b expected 01", n, ack); end
            checks++;
            if (data !== exp_d) begin errors++; $display("FAIL single_data%0d: got %h expected %h", n, data, exp_d); end
            checks++;
            if (lat != STEPS + 1) begin errors++; $display("FAIL single_latency%0d: got %0d expected %0d", n, lat, STEPS + 1); end
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_done%0d: got %b expected 1", n, busy); end
            tick();
            checks++;
            if (ack !== 2'b00 || busy !== 1'b0) begin
                errors++; $display("FAIL single_after%0d: got ack=%b busy=%b expected ack=00 busy=0", n, ack, busy);
            end
            checks++;
            if (data !== exp_d) begin errors++; $display("FAIL single_hold%0d: got %h expected %h", n, data, exp_d); end
        end
    endtask

    task automatic test_tie();
        logic [7:0] exp_d;
        int lat;
        apply_reset();
        req = 2'b11;
        wait_ack(lat);
        model_sample(exp_d);
        req = 2'b10;
        checks++;
        if (ack !== 2'b01 || data !== exp_d) begin
            errors++; $display("FAIL tie_first: got ack=%b data=%h expected ack=01 data=%h", ack, data, exp_d);
        end
        wait_ack(lat);
        model_sample(exp_d);
        req = 2'b00;
        last_served = 1'b1;
        checks++;
        if (ack !== 2'b10 || data !== exp_d) begin
            errors++; $display("FAIL tie_second: got ack=%b data=%h expected ack=10 data=%h", ack, data, exp_d);
        end
        checks++;
        if (lat != STEPS + 2) begin errors++; $display("FAIL tie_latency: got %0d expected %0d", lat, STEPS + 2); end
        tick();
    endtask

    task automatic test_seed_zero();
        logic [7:0] exp_d;
        int lat;
        seed_we = 1'b1;
        seed = 8'h00;
        req = 2'b10;
        tick();
        seed_we = 1'b0;
        model_seed(8'h00);
        wait_ack(lat);
        model_sample(exp_d);
        req = 2'b00;
        last_served = 1'b1;
        checks++;
        if (ack !== 2'b10 || data !== exp_d) begin
            errors++; $display("FAIL seed_zero: got ack=%b data=%h expected ack=10 data=%h", ack, data, exp_d);
        end
        checks++;
        if (lat + 1 != STEPS + 2) begin errors++; $display("FAIL seed_delay: got %0d expected %0d", lat + 1, STEPS + 2); end
        tick();
    endtask

    task automatic test_seed_in_shift();
        logic [7:0] exp_d;
        int lat;
        req = 2'b01;
        tick();
        tick();
        tick();
        seed_we = 1'b1;
        seed = 8'hA5;
        tick();
        seed_we = 1'b0;
        wait_ack(lat);
        model_sample(exp_d);
        req = 2'b00;
        last_served = 1'b0;
        checks++;
        if (ack !== 2'b01 || data !== exp_d) begin
            errors++; $display("FAIL seed_in_shift: got ack=%b data=%h expected ack=01 data=%h", ack, data, exp_d);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_d;
        int lat;
        int pulses;
        req = 2'b01;
        tick();
        tick();
        tick();
        tick();
        ar = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || ack !== 2'b00 || data !== 8'h00) begin
            errors++; $display("FAIL mid_reset: got busy=%b ack=%b data=%h expected 0/00/00", busy, ack, data);
        end
        req = 2'b00;
        tick();
        ar = 1'b1;
        pos = 0;
        last_served = 1'b1;
        pulses = 0;
        for (int i = 0; i < 2 * STEPS; i++) begin
            tick();
            if (ack != 2'b00) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL mid_reset_lost_ack: got %0d pulses expected 0", pulses); end
        req = 2'b01;
        wait_ack(lat);
        model_sample(exp_d);
        req = 2'b00;
        last_served = 1'b0;
        checks++;
        if (ack !== 2'b01 || data !== exp_d) begin
            errors++; $display("FAIL mid_reset_rerequest: got ack=%b data=%h expected ack=01 data=%h", ack, data, exp_d);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d;
        logic seen [256];
        int lat;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        apply_reset();
        req = 2'b01;
        for (int n = 0; n < PERIOD; n++) begin
            wait_ack(lat);
            model_sample(exp_d);
            if (n == PERIOD - 1) req = 2'b00;
            checks++;
            if (ack !== 2'b01 || data !== exp_d) begin
                errors++; $display("FAIL b2b_sample%0d: got ack=%b data=%h expected ack=01 data=%h", n, ack, data, exp_d);
            end
            checks++;
            if (lat != ((n == 0) ? STEPS + 1 : STEPS + 2)) begin
                errors++; $display("FAIL b2b_period%0d: got %0d expected %0d", n, lat, (n == 0) ? STEPS + 1 : STEPS + 2);
            end
            checks++;
            if (seen[data]) begin errors++; $display("FAIL b2b_duplicate%0d: got repeat of %h expected new value", n, data); end
            seen[data] = 1'b1;
        end
        last_served = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [7:0] exp_d;
        logic [7:0] rs;
        logic [1:0] req_v;
        logic [1:0] exp_ack;
        logic       idx;
        int lat;
        apply_reset();
        req_v = 2'b00;
        for (int n = 0; n < 40; n++) begin
            if (req_v == 2'b00 && $urandom_range(0, 3) == 0) begin
                rs = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 3) == 0) rs = 8'h00;
                seed = rs;
                seed_we = 1'b1;
                tick();
                seed_we = 1'b0;
                model_seed(rs);
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL rand_seed_busy%0d: got %b expected 0", n, busy); end
            end else begin
                req_v = req_v | 2'($urandom_range(1, 3));
                req = req_v;
                if (req_v == 2'b01) idx = 1'b0;
                else if (req_v == 2'b10) idx = 1'b1;
                else idx = ~last_served;
                exp_ack = idx ? 2'b10 : 2'b01;
                wait_ack(lat);
                model_sample(exp_d);
                last_served = idx;
                req_v = req_v & ~exp_ack;
                req = req_v;
                checks++;
                if (ack !== exp_ack || data !== exp_d) begin
                    errors++; $display("FAIL rand_grant%0d: got ack=%b data=%h expected ack=%b data=%h", n, ack, data, exp_ack, exp_d);
                end
                checks++;
                if (lat != STEPS + 1) begin errors++; $display("FAIL rand_latency%0d: got %0d expected %0d", n, lat, STEPS + 1); end
                tick();
            end
        end
        req = 2'b00;
        tick();
        tick();
    endtask

    initial begin
        build_table();
        test_reset();
        test_single();
        test_tie();
        test_seed_zero();
        test_seed_in_shift();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rng_share_ctrl.md
Name: rng_share_ctrl

Overview:
- Sequencing and arbitration controller for the 8-bit pseudorandom generator (polynomial x^8+x^6+x^5+x^4+1).
- Shares one LFSR between two requesters using round-robin arbitration and a req/ack handshake.
- Steps the LFSR a fixed number of shifts per sample to decorrelate consecutive outputs, and supports run-time seed loading.
- Sits between game/control logic and the random source.

Parameters:
STEPS, 8, LFSR shifts per delivered sample; legal range 1..255.

Ports:
clk  input  1  system clock, rising edge.
ar  input  1  reset; asynchronous, active-low.
seed_we  input  1  seed write strobe; honoured only in IDLE.
seed  input  8  seed value loaded on seed_we.
req  input  2  level request per requester; held until the matching ack.
ack  output  2  one-cycle grant/data-valid pulse per requester.
data  output  8  sample delivered with ack; held until the next ack.
busy  output  1  high in SHIFT and DONE.

Behaviour:
- Reset (ar low, asynchronous):
  - state=IDLE, lfsr=8'h01, data=8'h00, ack=2'b00, busy=0, count=0.
  - rr pointer set so that requester 0 wins the first tie.
- LFSR step, only when step_en=1: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. With step_en=0 the LFSR holds.
- IDLE:
  - seed_we=1: lfsr <= (seed==0) ? 8'h01 : seed. Zero-lockup guard. seed_we has priority over req in the same cycle; requests wait one cycle.
  - Else, if any req bit is set: grant one, latch grant index, count <= STEPS, go to SHIFT.
  - Arbitration:
    - Only one requester active: that requester is granted.
    - Both active: the requester not served last is granted. rr pointer updates on each ack.
- SHIFT:
  - step_en=1 every cycle; count decrements.
  - On the cycle count reaches 1, the final shift occurs and the state moves to DONE.
  - seed_we is ignored.
  - req deassertion by the granted requester does not abort; the sample is still delivered.
- DONE (1 cycle):
  - data <= lfsr; ack[grant] = 1 for exactly this cycle; go to IDLE.
- Latency: req sampled high in IDLE at cycle 0 gives ack at cycle STEPS+1, so a sample every STEPS+2 cycles under back-to-back load.
- Requester protocol:
  - req must drop on the cycle after ack.
  - If req is still high in the following IDLE cycle, it is treated as a new request.
- The LFSR never advances outside SHIFT, so the sample sequence is deterministic given seed and request count.
- data is stable between acks; ack bits are mutually exclusive.
- Reset mid-operation: any state returns to IDLE with the reset values above; the pending ack is lost and requesters must re-request.

Decomposition:
- Shared package:
  - State encoding constants (S_IDLE, S_SHIFT, S_DONE).
  - LFSR width (8).
  - Reset seed 8'h01.
  - Tap positions.
- Sub-module lfsr8_en: 8-bit LFSR with step_en, load, and load_val inputs. The same asynchronous active-low reset is used, with reset value 8'h01.
- Arbiter, counter and FSM stay in rng_share_ctrl.

Test Plan:
- After reset, STEPS=8, pulse req=01 → ack[0] 9 cycles later, data=8'h1C. Repeat on req[0] → data=8'h4B.
- req=11 held at the same edge from reset → ack[0] with 8'h1C first, then ack[1] with 8'h4B. Both requesters are served, neither twice in a row.
- seed_we=1 with seed=8'h00 in IDLE, then req=10 → seed is substituted with 8'h01, so ack[1] with data=8'h1C. The same cycle carries seed_we and req, so the grant is delayed one cycle.
- seed_we pulsed during SHIFT with seed=8'hA5 → ignored; the delivered sample matches the unseeded sequence.
- ar low for 1 cycle in mid-SHIFT → ack never pulses, busy=0, data=8'h00. The next request returns 8'h1C.
- req[0] held high continuously → acks every STEPS+2 cycles. Samples follow 8'h1C, 8'h4B, ..., with no duplicates over 255 consecutive lfsr states.
